display_scan_scheduler: RTL

- Time-multiplexing scheduler for the board's DIGITS-wide common-anode seven-segment display.
- Owns an internal scan prescaler and a blink-phase divider.
- Cycles one digit at a time, with an all-off guard interval between digits to suppress ghosting.
- Snapshots per-digit nibble, enable, blink and decimal-point inputs at each slot start, then drives active-low anode/segment pins.

---
 rtl/display_scan_scheduler.sv | 181 ++++++++++++++++++
 1 files changed

// File: rtl/display_scan_scheduler.sv
// Time-multiplexed scan driver for a common-anode seven-segment display.
// Each digit gets a lit slot followed by an all-dark guard interval.
module display_scan_scheduler #(
    parameter int CLK_HZ       = 100000000,
    parameter int SCAN_HZ      = 1000,
    parameter int GUARD_CYCLES = 4,
    parameter int BLINK_HZ     = 2,
    parameter int DIGITS       = 8
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  en_i,
    input  logic [4*DIGITS-1:0]   digit_data_i,
    input  logic [DIGITS-1:0]     digit_en_i,
    input  logic [DIGITS-1:0]     blink_mask_i,
    input  logic [DIGITS-1:0]     dp_i,
    output logic [DIGITS-1:0]     an_o,
    output logic [6:0]            seg_o,
    output logic                  dp_o,
    output logic                  frame_o
);

    localparam int SCAN_DIV  = CLK_HZ / SCAN_HZ;
    localparam int BLINK_DIV = CLK_HZ / (2 * BLINK_HZ);
    localparam int IDX_W     = $clog2(DIGITS);
    localparam int PRE_W     = $clog2(SCAN_DIV);
    localparam int GRD_W     = (GUARD_CYCLES > 1) ? $clog2(GUARD_CYCLES) : 1;
    localparam int BLK_W     = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

    typedef enum logic [1:0] {IDLE, SCAN, GUARD} state_t;

    state_t              state_q, state_d;
    logic [IDX_W-1:0]    index_q, index_d;
    logic [PRE_W-1:0]    presc_q, presc_d;
    logic [GRD_W-1:0]    guard_q, guard_d;
    logic [BLK_W-1:0]    blink_cnt_q, blink_cnt_d;
    logic                blink_phase_q, blink_phase_d;
    logic [DIGITS-1:0]   an_q, an_d;
    logic [6:0]          seg_q, seg_d;
    logic                dp_q, dp_d;
    logic                frame_q, frame_d;

    logic [IDX_W-1:0]    next_idx;
    logic [IDX_W-1:0]    slot_idx;
    logic [3:0]          snap_nib;
    logic                snap_blank;

    function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
        case (nib)
            4'h0:    hex_to_seg = 7'b1000000;
            4'h1:    hex_to_seg = 7'b1111001;
            4'h2:    hex_to_seg = 7'b0100100;
            4'h3:    hex_to_seg = 7'b0110000;
            4'h4:    hex_to_seg = 7'b0011001;
            4'h5:    hex_to_seg = 7'b0010010;
            4'h6:    hex_to_seg = 7'b0000010;
            4'h7:    hex_to_seg = 7'b1111000;
            4'h8:    hex_to_seg = 7'b0000000;
            4'h9:    hex_to_seg = 7'b0010000;
            4'hA:    hex_to_seg = 7'b0001000;
            4'hB:    hex_to_seg = 7'b0000011;
            4'hC:    hex_to_seg = 7'b1000110;
            4'hD:    hex_to_seg = 7'b0100001;
            4'hE:    hex_to_seg = 7'b0000110;
            default: hex_to_seg = 7'b0001110;
        endcase
    endfunction

    // A slot always starts either from IDLE (digit 0) or at the end of a guard (next digit).
    assign next_idx   = (index_q == IDX_W'(DIGITS - 1)) ? '0 : index_q + IDX_W'(1);
    assign slot_idx   = (state_q == GUARD) ? next_idx : '0;
    assign snap_nib   = digit_data_i[{slot_idx, 2'b00} +: 4];
    assign snap_blank = !digit_en_i[slot_idx] | (blink_phase_q & blink_mask_i[slot_idx]);

    always_comb begin
        state_d       = state_q;
        index_d       = index_q;
        presc_d       = presc_q;
        guard_d       = guard_q;
        blink_cnt_d   = blink_cnt_q;
        blink_phase_d = blink_phase_q;
        an_d          = an_q;
        seg_d         = seg_q;
        dp_d          = dp_q;
        frame_d       = 1'b0;

        if (state_q != IDLE) begin
            if (blink_cnt_q == BLK_W'(BLINK_DIV - 1)) begin
                blink_cnt_d   = '0;
                blink_phase_d = !blink_phase_q;
            end else begin
                blink_cnt_d = blink_cnt_q + BLK_W'(1);
            end
        end

        case (state_q)
            IDLE: begin
                if (en_i) begin
                    state_d = SCAN;
                    index_d = '0;
                    presc_d = '0;
                    an_d    = snap_blank ? '1 : ~(DIGITS'(1) << slot_idx);
                    seg_d   = snap_blank ? 7'h7F : hex_to_seg(snap_nib);
                    dp_d    = snap_blank | !dp_i[slot_idx];
                end
            end
            SCAN: begin
                if (presc_q == PRE_W'(SCAN_DIV - 1)) begin
                    state_d = GUARD;
                    presc_d = '0;
                    guard_d = '0;
                    an_d    = '1;
                    seg_d   = 7'h7F;
                    dp_d    = 1'b1;
                    frame_d = (index_q == IDX_W'(DIGITS - 1));
                end else begin
                    presc_d = presc_q + PRE_W'(1);
                end
            end
            GUARD: begin
                if (guard_q == GRD_W'(GUARD_CYCLES - 1)) begin
                    state_d = SCAN;
                    index_d = next_idx;
                    guard_d = '0;
                    an_d    = snap_blank ? '1 : ~(DIGITS'(1) << slot_idx);
                    seg_d   = snap_blank ? 7'h7F : hex_to_seg(snap_nib);
                    dp_d    = snap_blank | !dp_i[slot_idx];
                end else begin
                    guard_d = guard_q + GRD_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase

        // Disable overrides everything, including a frame pulse due this cycle.
        if (!en_i) begin
            state_d       = IDLE;
            index_d       = '0;
            presc_d       = '0;
            guard_d       = '0;
            blink_cnt_d   = '0;
            blink_phase_d = 1'b0;
            an_d          = '1;
            seg_d         = 7'h7F;
            dp_d          = 1'b1;
            frame_d       = 1'b0;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q       <= IDLE;
            index_q       <= '0;
            presc_q       <= '0;
            guard_q       <= '0;
            blink_cnt_q   <= '0;
            blink_phase_q <= 1'b0;
            an_q          <= '1;
            seg_q         <= 7'h7F;
            dp_q          <= 1'b1;
            frame_q       <= 1'b0;
        end else begin
            state_q       <= state_d;
            index_q       <= index_d;
            presc_q       <= presc_d;
            guard_q       <= guard_d;
            blink_cnt_q   <= blink_cnt_d;
            blink_phase_q <= blink_phase_d;
            an_q          <= an_d;
            seg_q         <= seg_d;
            dp_q          <= dp_d;
            frame_q       <= frame_d;
        end
    end

    assign an_o    = an_q;
    assign seg_o   = seg_q;
    assign dp_o    = dp_q;
    assign frame_o = frame_q;

endmodule
